// File: rtl/mem_flush_sequencer.sv
// Ordered maintenance sequencer: MSHR clear -> L1D/L2 sync -> per-level TLB flush.
// Define FLUSH_SEQ_TIMEOUT_EN to bound the SYNC wait and report err_o on expiry.
module mem_flush_sequencer #(
    parameter int TLB_LVLS     = 2,
    parameter int ASID_LEN     = 16,
    parameter int VPN_LEN      = 27,
    parameter int SYNC_TIMEOUT = 1023
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [1:0]            req_kind_i,
    input  logic                  req_rs1_zero_i,
    input  logic                  req_rs2_zero_i,
    input  logic [ASID_LEN-1:0]   req_asid_i,
    input  logic [VPN_LEN-1:0]    req_vpn_i,
    input  logic [3:0]            req_except_code_i,
    output logic                  stall_o,
    output logic                  flush_o,
    output logic                  abort_o,
    output logic                  clr_itlb_mshr_o,
    output logic                  clr_dmshr_o,
    output logic                  synch_l1dc_l2c_o,
    input  logic                  l2c_update_done_i,
    output logic [2*TLB_LVLS-1:0] tlb_flush_type_o,
    output logic [ASID_LEN-1:0]   flush_asid_o,
    output logic [VPN_LEN-1:0]    flush_page_o,
    input  logic [TLB_LVLS-1:0]   tlb_flush_ack_i,
    output logic                  done_o,
    output logic                  err_o
);

    localparam logic [1:0] KIND_FENCEI = 2'd0;
    localparam logic [1:0] KIND_SFENCE = 2'd1;
    localparam logic [1:0] KIND_EXCEPT = 2'd2;

    localparam logic [1:0] FLUSH_NONE = 2'd0;
    localparam logic [1:0] FLUSH_ALL  = 2'd1;
    localparam logic [1:0] FLUSH_ASID = 2'd2;
    localparam logic [1:0] FLUSH_PAGE = 2'd3;

    localparam logic [3:0] E_I_ADDR_MISALIGNED  = 4'd0;
    localparam logic [3:0] E_I_ACCESS_FAULT     = 4'd1;
    localparam logic [3:0] E_ILLEGAL_INSTR      = 4'd2;
    localparam logic [3:0] E_LD_ADDR_MISALIGNED = 4'd4;
    localparam logic [3:0] E_LD_ACCESS_FAULT    = 4'd5;
    localparam logic [3:0] E_ST_ADDR_MISALIGNED = 4'd6;
    localparam logic [3:0] E_ST_ACCESS_FAULT    = 4'd7;
    localparam logic [3:0] E_ENV_CALL_SMODE     = 4'd9;
    localparam logic [3:0] E_ENV_CALL_MMODE     = 4'd11;
    localparam logic [3:0] E_INSTR_PAGE_FAULT   = 4'd12;
    localparam logic [3:0] E_LD_PAGE_FAULT      = 4'd13;
    localparam logic [3:0] E_ST_PAGE_FAULT      = 4'd15;

    if (TLB_LVLS < 1 || TLB_LVLS > 4 || SYNC_TIMEOUT < 1) begin : g_bad_params
        $error("mem_flush_sequencer: TLB_LVLS must be 1..4 and SYNC_TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SYNC,
        S_TLB_FLUSH,
        S_DONE
    } state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [1:0]            r_kind;
    logic [3:0]            r_code;
    logic                  r_rs1_zero;
    logic                  r_rs2_zero;
    logic [ASID_LEN-1:0]   r_asid;
    logic [VPN_LEN-1:0]    r_vpn;
    logic [TLB_LVLS-1:0]   w_acked;
    logic                  w_all_acked;
    logic                  w_accept;
    logic                  w_sync_timeout;
    logic [1:0]            w_flush_type;
    logic                  w_i_fault;
    logic                  w_lsu_fault;
    logic                  w_page_fault;
    logic                  w_ecall_sm;

    assign req_ready_o  = (r_state == S_IDLE);
    assign stall_o      = (r_state != S_IDLE);
    assign w_accept     = req_valid_i && req_ready_o;
    assign flush_asid_o = r_asid;
    assign flush_page_o = r_vpn;

    assign w_i_fault    = (r_code == E_I_ADDR_MISALIGNED) || (r_code == E_I_ACCESS_FAULT) ||
                          (r_code == E_INSTR_PAGE_FAULT);
    assign w_lsu_fault  = (r_code == E_LD_ADDR_MISALIGNED) || (r_code == E_LD_ACCESS_FAULT) ||
                          (r_code == E_ST_ADDR_MISALIGNED) || (r_code == E_ST_ACCESS_FAULT) ||
                          (r_code == E_LD_PAGE_FAULT) || (r_code == E_ST_PAGE_FAULT);
    assign w_page_fault = (r_code == E_INSTR_PAGE_FAULT) || (r_code == E_LD_PAGE_FAULT) ||
                          (r_code == E_ST_PAGE_FAULT);
    assign w_ecall_sm   = (r_code == E_ENV_CALL_SMODE) || (r_code == E_ENV_CALL_MMODE);

    // Page faults always invalidate a single page; SFENCE picks its scope from rs1/rs2.
    always_comb begin
        w_flush_type = FLUSH_PAGE;
        if (r_kind == KIND_SFENCE && r_rs1_zero) begin
            w_flush_type = r_rs2_zero ? FLUSH_ALL : FLUSH_ASID;
        end
    end

`ifdef FLUSH_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(SYNC_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYNC_TIMEOUT - 1);

    logic [CNT_W-1:0] r_sync_cnt;
    logic             r_err;

    assign w_sync_timeout = (r_state == S_SYNC) && !l2c_update_done_i && (r_sync_cnt == CNT_LAST);
    assign err_o          = r_err && (r_state == S_DONE);

    always_ff @(posedge clk_i) begin
        if (rst_i || r_state != S_SYNC) begin
            r_sync_cnt <= '0;
        end else begin
            r_sync_cnt <= r_sync_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || w_accept) begin
            r_err <= 1'b0;
        end else if (w_sync_timeout) begin
            r_err <= 1'b1;
        end
    end
`else
    assign w_sync_timeout = 1'b0;
    assign err_o          = 1'b0;
`endif

    // Sticky per-level acks; an ack in the same cycle already counts toward completion.
    for (genvar gi = 0; gi < TLB_LVLS; gi++) begin : g_lvl
        logic r_ack;

        always_ff @(posedge clk_i) begin
            if (rst_i || r_state != S_TLB_FLUSH) begin
                r_ack <= 1'b0;
            end else if (tlb_flush_ack_i[gi]) begin
                r_ack <= 1'b1;
            end
        end

        assign w_acked[gi] = r_ack;
        assign tlb_flush_type_o[2*gi +: 2] =
            (r_state == S_TLB_FLUSH && !r_ack) ? w_flush_type : FLUSH_NONE;
    end

    assign w_all_acked = &(w_acked | tlb_flush_ack_i);

    always_comb begin
        w_state_next     = r_state;
        flush_o          = 1'b0;
        abort_o          = 1'b0;
        clr_itlb_mshr_o  = 1'b0;
        clr_dmshr_o      = 1'b0;
        synch_l1dc_l2c_o = 1'b0;
        done_o           = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                case (r_kind)
                    KIND_FENCEI: begin
                        clr_itlb_mshr_o = 1'b1;
                        w_state_next    = S_SYNC;
                    end
                    KIND_SFENCE: begin
                        clr_itlb_mshr_o = 1'b1;
                        clr_dmshr_o     = 1'b1;
                        w_state_next    = S_SYNC;
                    end
                    KIND_EXCEPT: begin
                        flush_o         = 1'b1;
                        clr_itlb_mshr_o = w_i_fault;
                        clr_dmshr_o     = w_lsu_fault;
                        abort_o         = (r_code == E_ILLEGAL_INSTR);
                        if (w_ecall_sm) begin
                            w_state_next = S_SYNC;
                        end else if (w_page_fault) begin
                            w_state_next = S_TLB_FLUSH;
                        end else begin
                            w_state_next = S_DONE;
                        end
                    end
                    default: w_state_next = S_DONE;
                endcase
            end
            S_SYNC: begin
                synch_l1dc_l2c_o = 1'b1;
                if (l2c_update_done_i) begin
                    w_state_next = (r_kind == KIND_SFENCE) ? S_TLB_FLUSH : S_DONE;
                end else if (w_sync_timeout) begin
                    w_state_next = S_DONE;
                end
            end
            S_TLB_FLUSH: begin
                if (w_all_acked) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done_o       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_kind     <= 2'd0;
            r_code     <= 4'd0;
            r_rs1_zero <= 1'b0;
            r_rs2_zero <= 1'b0;
            r_asid     <= '0;
            r_vpn      <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_kind     <= req_kind_i;
                r_code     <= req_except_code_i;
                r_rs1_zero <= req_rs1_zero_i;
                r_rs2_zero <= req_rs2_zero_i;
                r_asid     <= req_asid_i;
                r_vpn      <= req_vpn_i;
            end
        end
    end

endmodule
